// File: rtl/writeback_arbiter_pkg.sv
// Shared types and constants for the register-file writeback stage.
package writeback_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;
    localparam logic [ADDR_W-1:0] REG_LAST = ADDR_W'(31);

    // One buffered FP result; hi is only meaningful for double writes.
    typedef struct packed {
        logic [ADDR_W-1:0] dstReg;
        logic              isDouble;
        logic [DATA_W-1:0] lo;
        logic [DATA_W-1:0] hi;
    } fpEntry_t;

    // Register 0 is never written, and a double at the last index would wrap its pair.
    function automatic logic fpDestIllegal(input fpEntry_t e);
        return (e.dstReg == REG_ZERO) || (e.isDouble && (e.dstReg == REG_LAST));
    endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Result buses into the writeback stage and register-file write ports out of it.
interface writeback_arbiter_if;
    import writeback_arbiter_pkg::*;

    logic              int_valid;
    logic [ADDR_W-1:0] int_reg;
    logic [DATA_W-1:0] int_data;
    logic              int_stall;

    logic              fp_valid;
    logic              fp_ready;
    logic [ADDR_W-1:0] fp_reg;
    logic              fp_double;
    logic [DATA_W-1:0] fp_data_lo;
    logic [DATA_W-1:0] fp_data_hi;

    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic              regWrite;
    logic [ADDR_W-1:0] writeRegf;
    logic [DATA_W-1:0] writeData1f;
    logic [DATA_W-1:0] writeData2f;
    logic              regWritef;
    logic              regDWritef;
    logic              err_fp_reg;

    // Producer side: execution units feeding results, register file observing writes.
    modport master (
        output int_valid, int_reg, int_data,
        output fp_valid, fp_reg, fp_double, fp_data_lo, fp_data_hi,
        input  int_stall, fp_ready,
        input  writeReg, writeData, regWrite,
        input  writeRegf, writeData1f, writeData2f, regWritef, regDWritef, err_fp_reg
    );

    // Writeback stage side.
    modport slave (
        input  int_valid, int_reg, int_data,
        input  fp_valid, fp_reg, fp_double, fp_data_lo, fp_data_hi,
        output int_stall, fp_ready,
        output writeReg, writeData, regWrite,
        output writeRegf, writeData1f, writeData2f, regWritef, regDWritef, err_fp_reg
    );

endinterface

// File: rtl/writeback_arbiter_fp_fifo.sv
// Synchronous FIFO holding FP results until the register file has a free write slot.
module wb_fp_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  fpEntry_t pushData,
    input  logic     pop,
    output logic     ready,
    output logic     empty,
    output fpEntry_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countNext;
    fpEntry_t         mem [DEPTH];

    assign countNext = count + CNT_W'(push) - CNT_W'(pop);
    assign head      = mem[rdPtr];

    // Pointers, occupancy and the registered ready/empty flags; ready stays low in reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            ready <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            count <= countNext;
            ready <= (countNext != CNT_W'(DEPTH));
            empty <= (countNext == '0);
        end
    end

    // Entry storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback stage: serializes integer and FP results onto the register-file write ports.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int FP_DEPTH     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input logic               clk,
    input logic               rst_n,
    writeback_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    fpEntry_t         pushEntry;
    fpEntry_t         headEntry;
    logic             fifoReady;
    logic             fifoEmpty;
    logic             fpPush;
    logic             fpPop;
    logic             headIllegal;
    logic [CNT_W-1:0] starveCnt;
    logic [CNT_W-1:0] starveNext;

    assign pushEntry = '{dstReg: bus.fp_reg, isDouble: bus.fp_double,
                         lo: bus.fp_data_lo, hi: bus.fp_data_hi};
    assign fpPush      = bus.fp_valid && fifoReady;
    // Integer results cannot wait, so the FIFO only drains on int-free cycles.
    assign fpPop       = !bus.int_valid && !fifoEmpty;
    assign headIllegal = fpDestIllegal(headEntry);
    assign bus.fp_ready = fifoReady;

    wb_fp_fifo #(.DEPTH(FP_DEPTH)) fpFifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fpPush),
        .pushData (pushEntry),
        .pop      (fpPop),
        .ready    (fifoReady),
        .empty    (fifoEmpty),
        .head     (headEntry)
    );

    // Count int wins that leave FP waiting; the limit cycle always restarts the count.
    always_comb begin
        starveNext = starveCnt;
        if (fifoEmpty || fpPop || (starveCnt == CNT_W'(STARVE_LIMIT))) begin
            starveNext = '0;
        end else if (bus.int_valid) begin
            starveNext = starveCnt + CNT_W'(1);
        end
    end

    // Starvation counter and the one-cycle stall request to upstream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starveCnt     <= '0;
            bus.int_stall <= 1'b0;
        end else begin
            starveCnt     <= starveNext;
            bus.int_stall <= (starveNext == CNT_W'(STARVE_LIMIT));
        end
    end

    // Registered write ports: integer grant or FIFO head, never both.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.regWrite    <= 1'b0;
            bus.writeReg    <= '0;
            bus.writeData   <= '0;
            bus.regWritef   <= 1'b0;
            bus.regDWritef  <= 1'b0;
            bus.writeRegf   <= '0;
            bus.writeData1f <= '0;
            bus.writeData2f <= '0;
            bus.err_fp_reg  <= 1'b0;
        end else begin
            bus.regWrite  <= bus.int_valid && (bus.int_reg != REG_ZERO);
            bus.writeReg  <= bus.int_valid ? bus.int_reg : '0;
            bus.writeData <= bus.int_valid ? bus.int_data : '0;

            bus.regWritef   <= fpPop && !headIllegal && !headEntry.isDouble;
            bus.regDWritef  <= fpPop && !headIllegal && headEntry.isDouble;
            bus.err_fp_reg  <= fpPop && headIllegal;
            bus.writeRegf   <= (fpPop && !headIllegal) ? headEntry.dstReg : '0;
            bus.writeData1f <= (fpPop && !headIllegal) ? headEntry.lo : '0;
            bus.writeData2f <= (fpPop && !headIllegal && headEntry.isDouble) ? headEntry.hi : '0;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for the writeback arbiter: directed vectors, corner sequences, random vs. model.
module tb_writeback_arbiter;

    localparam int FP_DEPTH     = 4;
    localparam int STARVE_LIMIT = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    writeback_arbiter_if bus();

    writeback_arbiter #(.FP_DEPTH(FP_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iV;
        logic [4:0]  iR;
        logic [31:0] iD;
        logic        fV;
        logic [4:0]  fR;
        logic        fDbl;
        logic [31:0] fLo;
        logic [31:0] fHi;
        logic        eW;
        logic        eWf;
        logic        eDWf;
        logic        eErr;
        logic [4:0]  eReg;
        logic [31:0] eDa;
        logic [31:0] eDb;
    } vec_t;

    typedef struct {
        logic [4:0]  r;
        logic        d;
        logic [31:0] lo;
        logic [31:0] hi;
    } mEntry_t;

    // Reference model state: a plain queue of pending FP results plus expected outputs.
    mEntry_t     mq[$];
    int          mCnt;
    logic        mReady, mStall;
    logic        eW, eWf, eDWf, eErr;
    logic [4:0]  eReg, eRegf;
    logic [31:0] eData, eD1, eD2;
    logic        prevStall;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic driveInt(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.int_valid = v;
        bus.int_reg   = r;
        bus.int_data  = d;
    endtask

    task automatic driveFp(input logic v, input logic [4:0] r, input logic dbl,
                           input logic [31:0] lo, input logic [31:0] hi);
        bus.fp_valid   = v;
        bus.fp_reg     = r;
        bus.fp_double  = dbl;
        bus.fp_data_lo = lo;
        bus.fp_data_hi = hi;
    endtask

    task automatic idle();
        driveInt(1'b0, 5'd0, 32'd0);
        driveFp(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    endtask

    function automatic logic [5:0] ctl();
        return {bus.regWrite, bus.regWritef, bus.regDWritef, bus.err_fp_reg,
                bus.int_stall, bus.fp_ready};
    endfunction

    function automatic logic [3:0] en4();
        return {bus.regWrite, bus.regWritef, bus.regDWritef, bus.err_fp_reg};
    endfunction

    // Expected outputs after the coming edge, from the current inputs and queued results.
    task automatic modelStep();
        mEntry_t e;
        bit      doPop, doPush, illegal;
        eW = 0; eWf = 0; eDWf = 0; eErr = 0;
        if (!rst_n) begin
            mq.delete();
            mCnt   = 0;
            mReady = 0;
            mStall = 0;
            return;
        end
        doPop  = !bus.int_valid && (mq.size() != 0);
        doPush = bus.fp_valid && mReady;
        if (bus.int_valid && bus.int_reg != 5'd0) begin
            eW = 1; eReg = bus.int_reg; eData = bus.int_data;
        end
        if (mq.size() == 0 || doPop || mCnt == STARVE_LIMIT) mCnt = 0;
        else if (bus.int_valid) mCnt = mCnt + 1;
        mStall = (mCnt == STARVE_LIMIT);
        if (doPop) begin
            e = mq.pop_front();
            illegal = (e.r == 5'd0) || (e.d && e.r == 5'd31);
            if (illegal) eErr = 1;
            else if (e.d) eDWf = 1;
            else eWf = 1;
            eRegf = e.r; eD1 = e.lo; eD2 = e.hi;
        end
        if (doPush) mq.push_back('{bus.fp_reg, bus.fp_double, bus.fp_data_lo, bus.fp_data_hi});
        mReady = (mq.size() < FP_DEPTH);
    endtask

    task automatic compareModel();
        chk("rand.ctl", ctl(), {eW, eWf, eDWf, eErr, mStall, mReady});
        if (eW) begin
            chk("rand.writeReg", bus.writeReg, eReg);
            chk("rand.writeData", bus.writeData, eData);
        end
        if (eWf || eDWf) begin
            chk("rand.writeRegf", bus.writeRegf, eRegf);
            chk("rand.writeData1f", bus.writeData1f, eD1);
        end
        if (eDWf) chk("rand.writeData2f", bus.writeData2f, eD2);
    endtask

    initial begin
        logic [4:0]  fillReg [4];
        logic        fillDbl [4];

        // iV iR iD | fV fR fDbl lo hi | eW eWf eDWf eErr eReg eDa eDb
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  1'b0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b0, 1'b0, 5'd5,  32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0,  1'b0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0, 32'h0};
        vecs[2] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0,  1'b0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 32'hFFFFFFFF, 32'h0};
        vecs[3] = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd4,  1'b1, 32'h1, 32'h2,
                    1'b0, 1'b0, 1'b1, 1'b0, 5'd4,  32'h1, 32'h2};
        vecs[4] = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd3,  1'b0, 32'hAAAA5555, 32'h77,
                    1'b0, 1'b1, 1'b0, 1'b0, 5'd3,  32'hAAAA5555, 32'h0};
        vecs[5] = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd31, 1'b1, 32'h5, 32'h6,
                    1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  32'h0, 32'h0};
        vecs[6] = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd0,  1'b0, 32'h7, 32'h0,
                    1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  32'h0, 32'h0};
        vecs[7] = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd30, 1'b1, 32'h3030, 32'h3131,
                    1'b0, 1'b0, 1'b1, 1'b0, 5'd30, 32'h3030, 32'h3131};
        vecs[8] = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd31, 1'b0, 32'h1F1F, 32'h0,
                    1'b0, 1'b1, 1'b0, 1'b0, 5'd31, 32'h1F1F, 32'h0};

        // Reset values, then ready rises one edge after release.
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        chk("reset.ctl", ctl(), 6'b000000);
        chk("reset.intPorts", {bus.writeReg, bus.writeData}, '0);
        rst_n = 1'b1;
        tick();
        chk("reset.readyAfter", ctl(), 6'b000001);

        // Table of single transactions: int seen after one edge, FP after two.
        for (int i = 0; i < 9; i++) begin
            idle();
            driveInt(vecs[i].iV, vecs[i].iR, vecs[i].iD);
            driveFp(vecs[i].fV, vecs[i].fR, vecs[i].fDbl, vecs[i].fLo, vecs[i].fHi);
            tick();
            idle();
            if (vecs[i].fV) tick();
            chk($sformatf("vec%0d.en", i), en4(),
                {vecs[i].eW, vecs[i].eWf, vecs[i].eDWf, vecs[i].eErr});
            if (vecs[i].eW) begin
                chk($sformatf("vec%0d.writeReg", i), bus.writeReg, vecs[i].eReg);
                chk($sformatf("vec%0d.writeData", i), bus.writeData, vecs[i].eDa);
            end
            if (vecs[i].eWf || vecs[i].eDWf) begin
                chk($sformatf("vec%0d.writeRegf", i), bus.writeRegf, vecs[i].eReg);
                chk($sformatf("vec%0d.writeData1f", i), bus.writeData1f, vecs[i].eDa);
            end
            if (vecs[i].eDWf) chk($sformatf("vec%0d.writeData2f", i), bus.writeData2f, vecs[i].eDb);
        end

        // Fill the FIFO under continuous int traffic, offer a fifth entry, then drain.
        fillReg = '{5'd2, 5'd4, 5'd6, 5'd8};
        fillDbl = '{1'b0, 1'b1, 1'b0, 1'b1};
        idle();
        tick();
        for (int k = 0; k < 4; k++) begin
            driveInt(1'b1, 5'd9, 32'h900 + k);
            driveFp(1'b1, fillReg[k], fillDbl[k], 32'h100 + k, 32'h200 + k);
            tick();
            chk($sformatf("fill%0d.ready", k), bus.fp_ready, (k < 3));
        end
        driveFp(1'b1, 5'd20, 1'b0, 32'hBAD, 32'h0);
        tick();
        chk("fill.fullHolds", bus.fp_ready, 1'b0);
        idle();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("drain%0d.en", k), en4(), {1'b0, !fillDbl[k], fillDbl[k], 1'b0});
            chk($sformatf("drain%0d.writeRegf", k), bus.writeRegf, fillReg[k]);
            chk($sformatf("drain%0d.writeData1f", k), bus.writeData1f, 32'h100 + k);
            if (fillDbl[k]) chk($sformatf("drain%0d.writeData2f", k), bus.writeData2f, 32'h200 + k);
            if (k == 0) chk("drain0.ready", bus.fp_ready, 1'b1);
        end
        tick();
        chk("drain.nothingExtra", en4(), 4'b0000);

        // Starvation: one FP entry waiting behind eight int grants.
        driveInt(1'b1, 5'd3, 32'h33);
        driveFp(1'b1, 5'd7, 1'b0, 32'hCAFE0007, 32'h0);
        tick();
        driveFp(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
        for (int g = 1; g <= STARVE_LIMIT; g++) begin
            tick();
            chk($sformatf("starve%0d.stall", g), bus.int_stall, (g == STARVE_LIMIT));
            chk($sformatf("starve%0d.noFp", g), bus.regWritef, 1'b0);
        end
        tick();
        chk("starve.stallCycleEn", {bus.int_stall, bus.regWrite, bus.regWritef}, 3'b010);
        driveInt(1'b0, 5'd0, 32'h0);
        tick();
        chk("starve.fpPop", en4(), 4'b0100);
        chk("starve.fpReg", bus.writeRegf, 5'd7);
        chk("starve.fpData", bus.writeData1f, 32'hCAFE0007);

        // Illegal destinations are consumed with an error pulse and no write.
        idle();
        driveFp(1'b1, 5'd31, 1'b1, 32'h11, 32'h22);
        tick();
        driveFp(1'b1, 5'd0, 1'b0, 32'h33, 32'h0);
        tick();
        chk("illegal.dbl31", en4(), 4'b0001);
        idle();
        tick();
        chk("illegal.single0", en4(), 4'b0001);
        tick();
        chk("illegal.after", en4(), 4'b0000);

        // Reset with three queued entries discards them.
        driveInt(1'b1, 5'd9, 32'h99);
        for (int k = 0; k < 3; k++) begin
            driveFp(1'b1, 5'(10 + 2 * k), 1'b0, 32'hA0 + k, 32'h0);
            tick();
        end
        rst_n = 1'b0;
        tick();
        chk("midReset.ctl", ctl(), 6'b000000);
        chk("midReset.ports", {bus.writeReg, bus.writeData, bus.writeRegf,
                               bus.writeData1f}, '0);
        rst_n = 1'b1;
        idle();
        tick();
        chk("midReset.readyNext", ctl(), 6'b000001);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("midReset.noStale%0d", k), en4(), 4'b0000);
        end

        // Randomized traffic against the queue model, with occasional resets.
        rst_n = 1'b0;
        idle();
        modelStep();
        tick();
        compareModel();
        prevStall = 1'b0;
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            if (prevStall && ($urandom_range(0, 3) != 0)) bus.int_valid = 1'b0;
            else bus.int_valid = ($urandom_range(0, 99) < 72);
            bus.int_reg    = 5'($urandom_range(0, 31));
            bus.int_data   = $urandom;
            bus.fp_valid   = ($urandom_range(0, 99) < 40);
            bus.fp_reg     = 5'($urandom_range(0, 31));
            bus.fp_double  = $urandom_range(0, 1) != 0;
            bus.fp_data_lo = $urandom;
            bus.fp_data_hi = $urandom;
            modelStep();
            tick();
            compareModel();
            prevStall = bus.int_stall;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
